// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Main control unit for a multicycle MIPS datapath. A Moore FSM walks each
// instruction through fetch / decode / execute / memory / writeback (3-5
// cycles), stretches the memory states on the memready handshake, decodes
// op/funct into the 3-bit ALU operation, and raises sticky flags for
// unsupported instructions and memory-wait timeouts.
//
// Configuration:
//   MIPS_CTRL_BNE_EN  when defined, opcode 000101 (bne) and its BNE state
//                     are compiled in; otherwise bne is an illegal opcode.
//
// Parameters:
//   TIMEOUT_W   width of the memory-wait counter; a timeout fires on the
//               (2^TIMEOUT_W-1)-th consecutive waiting cycle. Must be >= 2.
//
// Ports:
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   op, funct           instruction[31:26] and instruction[5:0]
//   zero                ALU zero flag (branch decision)
//   memready            memory finished the current access this cycle
//   pcen, irwrite       PC enable, instruction register load
//   memwrite, regwrite  memory write strobe, register file write
//   iord                memory address: 0 = PC, 1 = ALUOut
//   alusrca             ALU A: 0 = PC, 1 = A register
//   alusrcb             ALU B: 00 B, 01 4, 10 SignImm, 11 SignImm<<2
//   memtoreg, regdst    writeback source (1 = memory), dest (1 = rd)
//   pcsrc               next PC: 00 ALU result, 01 ALUOut, 10 jump target
//   alucontrol          010 add, 110 sub, 000 and, 001 or, 111 slt
//   illegal, memfault   sticky error flags, cleared only by reset
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter int TIMEOUT_W = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic       memfault
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Counter value on the cycle whose wait would make it 2^TIMEOUT_W-1.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_ADDIEXEC,
    S_ADDIWB,
    S_BEQ,
`ifdef MIPS_CTRL_BNE_EN
    S_BNE,
`endif
    S_JUMP
  } state_t;

  state_t                 state;
  state_t                 next_state;
  state_t                 decode_next;
  logic                   instr_ok;
  logic                   funct_ok;
  logic [2:0]             funct_alu;
  logic [TIMEOUT_W-1:0]   wait_cnt;
  logic                   waiting;
  logic                   timeout;

  // -------------------------------------------------------------------------
  // Instruction decode (pure function of op/funct)
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    instr_ok    = 1'b1;
    decode_next = S_FETCH;
    case (op)
      OP_LW, OP_SW: decode_next = S_MEMADR;
      OP_RTYPE: begin
        if (funct_ok) decode_next = S_EXECUTE;
        else          instr_ok    = 1'b0;
      end
      OP_BEQ:       decode_next = S_BEQ;
`ifdef MIPS_CTRL_BNE_EN
      OP_BNE:       decode_next = S_BNE;
`endif
      OP_ADDI:      decode_next = S_ADDIEXEC;
      OP_J:         decode_next = S_JUMP;
      default:      instr_ok    = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Memory-wait watchdog
  // -------------------------------------------------------------------------
  assign waiting = !memready &&
                   (state == S_FETCH || state == S_MEMRD || state == S_MEMWR);
  assign timeout = waiting && (wait_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (!waiting || timeout || next_state != state) begin
      // A FETCH timeout keeps the state, so the clear must be explicit.
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + TIMEOUT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (!reset_n) state <= S_FETCH;
    else          state <= next_state;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    next_state = memready ? S_DECODE : S_FETCH;
      S_DECODE:   next_state = decode_next;
      S_MEMADR:   next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (memready)     next_state = S_MEMWB;
        else if (timeout) next_state = S_FETCH;
      end
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWR: begin
        if (memready || timeout) next_state = S_FETCH;
      end
      S_EXECUTE:  next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_ADDIEXEC: next_state = S_ADDIWB;
      S_ADDIWB:   next_state = S_FETCH;
      S_BEQ:      next_state = S_FETCH;
`ifdef MIPS_CTRL_BNE_EN
      S_BNE:      next_state = S_FETCH;
`endif
      S_JUMP:     next_state = S_FETCH;
      default:    next_state = S_FETCH;
    endcase
  end

  // -------------------------------------------------------------------------
  // Sticky error flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal  <= 1'b0;
      memfault <= 1'b0;
    end else begin
      if (state == S_DECODE && !instr_ok) illegal  <= 1'b1;
      if (timeout)                        memfault <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    pcen       = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    iord       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
    case (state)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = memready;
        pcen    = memready;
      end
      S_DECODE:   alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD:    iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB:   regwrite = 1'b1;
      S_BEQ: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = zero;
      end
`ifdef MIPS_CTRL_BNE_EN
      S_BNE: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = ~zero;
      end
`endif
      S_JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    // While reset is held the state is FETCH, but the write enables must not
    // follow memready into the datapath.
    if (!reset_n) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Each instruction is described as a list of phases (fetch, decode, ...)
// built from the instruction's CPI rules; each phase has a fixed control
// vector taken from the per-state output table. Outputs are sampled on the
// falling edge, inputs change 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       pcen, irwrite, memwrite, regwrite, iord, alusrca;
  logic [1:0] alusrcb;
  logic       memtoreg, regdst;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal, memfault;

  int n_checks = 0;
  int n_pass   = 0;

  logic [5:0] functs [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  mips_multicycle_ctrl #(.TIMEOUT_W(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .memready  (memready),
    .pcen      (pcen),
    .irwrite   (irwrite),
    .memwrite  (memwrite),
    .regwrite  (regwrite),
    .iord      (iord),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .memtoreg  (memtoreg),
    .regdst    (regdst),
    .pcsrc     (pcsrc),
    .alucontrol(alucontrol),
    .illegal   (illegal),
    .memfault  (memfault)
  );

  always #5 clk = ~clk;

  // {pcen,irwrite,memwrite,regwrite,iord,alusrca,alusrcb,memtoreg,regdst,pcsrc,alucontrol}
  logic [14:0] act_v;
  assign act_v = {pcen, irwrite, memwrite, regwrite, iord, alusrca, alusrcb,
                  memtoreg, regdst, pcsrc, alucontrol};

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic bit is_legal(input logic [5:0] o, input logic [5:0] f);
    bit fok;
    fok = (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
          (f == 6'b100101) || (f == 6'b101010);
    if (o == OP_R) return fok;
`ifdef MIPS_CTRL_BNE_EN
    if (o == OP_BNE) return 1'b1;
`endif
    return (o == OP_LW) || (o == OP_SW) || (o == OP_BEQ) || (o == OP_ADDI) || (o == OP_J);
  endfunction

  // Expected control vector for one phase of an instruction.
  function automatic logic [14:0] exp_ctl(input string ph, input logic m,
                                          input logic z, input logic [5:0] f);
    logic pe, ir, mw, rw, io, sa, mr, rd;
    logic [1:0] sb, ps;
    logic [2:0] al;
    {pe, ir, mw, rw, io, sa, mr, rd} = '0;
    sb = 2'b00; ps = 2'b00; al = 3'b010;
    case (ph)
      "F":  begin sb = 2'b01; pe = m; ir = m; end
      "D":  sb = 2'b11;
      "MA": begin sa = 1; sb = 2'b10; end
      "MR": io = 1;
      "WB": begin mr = 1; rw = 1; end
      "MW": begin io = 1; mw = 1; end
      "EX": begin sa = 1; al = alu_of(f); end
      "AW": begin rd = 1; rw = 1; end
      "AE": begin sa = 1; sb = 2'b10; end
      "AI": rw = 1;
      "BQ": begin sa = 1; al = 3'b110; ps = 2'b01; pe = z; end
      "BN": begin sa = 1; al = 3'b110; ps = 2'b01; pe = ~z; end
      "J":  begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {pe, ir, mw, rw, io, sa, sb, mr, rd, ps, al};
  endfunction

  // One clock of an instruction: drive memready, compare at the falling edge.
  task automatic step(input string ph, input logic m);
    logic [14:0] exp_v;
    memready = m;
    @(negedge clk);
    exp_v = exp_ctl(ph, m, zero, funct);
    n_checks++;
    if (act_v !== exp_v)
      $display("FAIL phase_%s t=%0t: got %b expected %b", ph, $time, act_v, exp_v);
    else
      n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Full instruction: fw fetch waits, mw memory waits.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int fw, input int mw);
    op = o; funct = f; zero = z;
    repeat (fw) step("F", 1'b0);
    step("F", 1'b1);
    step("D", 1'($urandom));
    if (!is_legal(o, f)) begin
      n_checks++;
      if (illegal !== 1'b1) $display("FAIL illegal_flag op=%b: got %b expected 1", o, illegal);
      else n_pass++;
      return;
    end
    case (o)
      OP_LW: begin
        step("MA", 1'($urandom));
        repeat (mw) step("MR", 1'b0);
        step("MR", 1'b1);
        step("WB", 1'($urandom));
      end
      OP_SW: begin
        step("MA", 1'($urandom));
        repeat (mw) step("MW", 1'b0);
        step("MW", 1'b1);
      end
      OP_R:    begin step("EX", 1'($urandom)); step("AW", 1'($urandom)); end
      OP_ADDI: begin step("AE", 1'($urandom)); step("AI", 1'($urandom)); end
      OP_BEQ:  step("BQ", 1'($urandom));
      OP_BNE:  step("BN", 1'($urandom));
      OP_J:    step("J", 1'($urandom));
      default: ;
    endcase
  endtask

  task automatic test_reset();
    logic [14:0] exp_v;
    reset_n = 1'b1; memready = 1'b1; op = OP_LW; funct = '0; zero = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    exp_v = exp_ctl("F", 1'b0, zero, funct);
    n_checks++;
    if (act_v !== exp_v) $display("FAIL reset_outputs: got %b expected %b", act_v, exp_v);
    else n_pass++;
    n_checks++;
    if ({illegal, memfault} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {illegal, memfault});
    else n_pass++;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_lw();
    run_instr(OP_LW, 6'b000000, 1'b0, 0, 0);
  endtask

  task automatic test_rtype_slt();
    run_instr(OP_R, 6'b101010, 1'b0, 0, 0);
  endtask

  task automatic test_beq();
    run_instr(OP_BEQ, 6'b000000, 1'b1, 0, 0);
    run_instr(OP_BEQ, 6'b000000, 1'b0, 0, 0);
  endtask

  task automatic test_sw_stall();
    run_instr(OP_SW, 6'b111000, 1'b0, 0, 3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int k;
      logic [5:0] o, f;
      k = $urandom_range(0, 9);
      f = 6'($urandom);
      case (k)
        0:       o = OP_LW;
        1:       o = OP_SW;
        2, 3:    begin o = OP_R; f = functs[$urandom_range(0, 4)]; end
        4:       o = OP_ADDI;
        5:       o = OP_BEQ;
        6:       o = OP_J;
        7:       o = OP_LW;
        8:       begin o = OP_R; f = functs[$urandom_range(0, 4)]; end
        default: o = OP_SW;
      endcase
      run_instr(o, f, 1'($urandom), $urandom_range(0, 6), $urandom_range(0, 6));
    end
  endtask

  task automatic test_mem_timeout();
    op = OP_LW; funct = '0; zero = 1'b0;
    step("F", 1'b1);
    step("D", 1'b1);
    step("MA", 1'b1);
    repeat (6) step("MR", 1'b0);
    n_checks++;
    if (memfault !== 1'b0) $display("FAIL memfault_early: got %b expected 0", memfault);
    else n_pass++;
    step("MR", 1'b0);
    n_checks++;
    if (memfault !== 1'b1) $display("FAIL memfault_rd: got %b expected 1", memfault);
    else n_pass++;
    step("F", 1'b1);
    step("D", 1'b1);
    step("MA", 1'b1);
    step("MR", 1'b1);
    step("WB", 1'b1);
  endtask

  task automatic test_fetch_timeout();
    apply_reset();
    op = OP_J; funct = '0; zero = 1'b0;
    repeat (6) step("F", 1'b0);
    n_checks++;
    if (memfault !== 1'b0) $display("FAIL fetch_memfault_early: got %b expected 0", memfault);
    else n_pass++;
    step("F", 1'b0);
    n_checks++;
    if (memfault !== 1'b1) $display("FAIL fetch_memfault: got %b expected 1", memfault);
    else n_pass++;
    repeat (6) step("F", 1'b0);
    step("F", 1'b1);
    step("D", 1'b0);
    step("J", 1'b0);
  endtask

  task automatic test_illegal_and_reset();
    logic [14:0] exp_v;
`ifdef MIPS_CTRL_BNE_EN
    run_instr(OP_BNE, 6'b000000, 1'b0, 0, 0);
    run_instr(OP_BNE, 6'b000000, 1'b1, 0, 0);
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
`else
    run_instr(OP_BNE, 6'b000000, 1'b0, 0, 0);
`endif
    step("F", 1'b1);
    op = OP_R; funct = 6'b100100;
    step("D", 1'b1);
    // Now in EXECUTE: reset asynchronously with memready high.
    memready = 1'b1;
    reset_n  = 1'b0;
    #1;
    exp_v = exp_ctl("F", 1'b0, zero, funct);
    n_checks++;
    if (act_v !== exp_v) $display("FAIL reset_mid_exec: got %b expected %b", act_v, exp_v);
    else n_pass++;
    n_checks++;
    if ({illegal, memfault} !== 2'b00) $display("FAIL reset_mid_exec_flags: got %b expected 00", {illegal, memfault});
    else n_pass++;
    @(posedge clk);
    #1 reset_n = 1'b1;
    run_instr(OP_ADDI, 6'b000000, 1'b0, 1, 0);
    run_instr(OP_R, 6'b000000, 1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype_slt();
    test_beq();
    test_sw_stall();
    test_random();
    test_mem_timeout();
    test_fetch_timeout();
    test_illegal_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control unit for the multicycle MIPS datapath, and the driving end of the ALU's `alucontrol` interface. A Moore state machine sequences each instruction through fetch, decode, execute, memory and writeback over 3–5 cycles. It stretches memory states on a `memready` handshake and emits every datapath enable and mux select. It decodes `op`/`funct` into the 3-bit ALU operation code and flags unsupported instructions and memory timeouts.

## Interface
- `TIMEOUT_W`, default 8: width of the memory-wait counter; timeout after 2^TIMEOUT_W−1 consecutive waiting cycles.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `op` in 6: instruction[31:26], from the instruction register.
- `funct` in 6: instruction[5:0].
- `zero` in 1: ALU zero flag.
- `memready` in 1: memory has completed the current access this cycle.
- `pcen` out 1: PC register enable.
- `irwrite` out 1: instruction register load.
- `memwrite` out 1: memory write strobe.
- `regwrite` out 1: register file write.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `alusrca` out 1: 0 = PC, 1 = A register.
- `alusrcb` out 2: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `memtoreg` out 1: register writeback source; 1 = memory data.
- `regdst` out 1: destination register; 1 = rd, 0 = rt.
- `pcsrc` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alucontrol` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal` out 1: sticky; an unsupported instruction was seen.
- `memfault` out 1: sticky; a memory-wait timeout occurred.

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010, bne 000101 (bne only with the macro enabled).
- R-type funct codes: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
- Default for every output in every state: 0, except `alucontrol` = 010.
- Per-state outputs and transitions:
  - FETCH: alusrcb=01, `irwrite` = `pcen` = `memready`. Goes to DECODE when `memready`=1, otherwise stays.
  - DECODE: alusrcb=11. Goes to MEMADR (lw/sw), EXECUTE (R), BEQ, BNE, ADDIEXEC or JUMP.
  - Unsupported op or R-type funct in DECODE: set `illegal` and go to FETCH.
  - MEMADR: alusrca=1, alusrcb=10. Goes to MEMRD (lw) or MEMWR (sw).
  - MEMRD: iord=1. Goes to MEMWB on `memready`.
  - MEMWB: memtoreg=1, regwrite=1. Goes to FETCH.
  - MEMWR: iord=1, `memwrite`=1 every cycle in the state. Goes to FETCH on `memready`.
  - EXECUTE: alusrca=1, alusrcb=00, `alucontrol` from `funct`. Goes to ALUWB.
  - ALUWB: regdst=1, regwrite=1. Goes to FETCH.
  - ADDIEXEC: alusrca=1, alusrcb=10. Goes to ADDIWB.
  - ADDIWB: regwrite=1. Goes to FETCH.
  - BEQ: alusrca=1, `alucontrol`=110, pcsrc=01, `pcen`=`zero`. Goes to FETCH.
  - BNE: as BEQ, but `pcen`=~`zero`.
  - JUMP: pcsrc=10, `pcen`=1. Goes to FETCH.
- Memory timeout:
  - The wait counter counts cycles in FETCH, MEMRD or MEMWR with `memready`=0. It clears on `memready`=1 or on any state change.
  - On reaching 2^TIMEOUT_W−1: set `memfault`.
  - In MEMRD or MEMWR, a timeout aborts the access and the FSM goes to FETCH. `regwrite` is never asserted for an aborted load.
  - In FETCH, a timeout leaves the FSM in FETCH with the counter cleared.
- `illegal` and `memfault` clear only on reset.

## Timing
- Reset (`reset_n` low, asynchronous):
  - State goes to FETCH; the counter, `illegal` and `memfault` clear to 0.
  - `pcen`, `irwrite`, `memwrite` and `regwrite` are forced to 0 while reset is held, regardless of `memready`.
  - All other outputs take their FETCH values.
- A reset during any state abandons the instruction; the first rising edge after release evaluates FETCH.
- Outputs are combinational from state. `irwrite`, `pcen`, `alucontrol` and BEQ/BNE `pcen` additionally depend on `memready`, `funct` and `zero` in the same cycle.
- CPI with `memready` held at 1: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3. Each low-`memready` cycle in a wait state adds 1.
- `memready` is sampled only in FETCH, MEMRD and MEMWR; it is ignored elsewhere.

## Configuration
- `MIPS_CTRL_BNE_EN` defined: BNE state and opcode 000101 are compiled in.
- `MIPS_CTRL_BNE_EN` undefined: opcode 000101 is unsupported and sets `illegal`; no BNE state exists.

## Test plan
- lw (op=100011), `memready`=1: states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles. In MEMWB, `regwrite`=1 and `memtoreg`=1. `pcen`=1 only in the FETCH cycle.
- R-type, funct=101010: `alucontrol`=111 in EXECUTE. In ALUWB, `regwrite`=1 and `regdst`=1. Next FETCH after 4 cycles.
- beq with `zero`=1, then with `zero`=0: BEQ `pcen`=1 and `pcsrc`=01 for the first, `pcen`=0 for the second. Each takes 3 cycles.
- sw with `memready` low for 3 cycles in MEMWR: `memwrite` held for 4 cycles, then FETCH.
- TIMEOUT_W=3, `memready` stuck at 0 in MEMRD: after 7 cycles `memfault`=1, FSM in FETCH, `regwrite` never 1.
- op=000101 without `MIPS_CTRL_BNE_EN`: `illegal`=1 after DECODE, FETCH next. Assert `reset_n`=0 mid-EXECUTE: `illegal`=0 and FETCH immediately, with all enables 0.
